mips_mult_div: RTL and testbench

//  Iterative multiply/divide unit with HI/LO registers; consumes the two operands read from the register file.

---
 rtl/mips_mult_div.sv | 157 +++++++++++++++
 tb/tb_mips_mult_div.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_mult_div.sv
// Iterative MIPS multiply/divide unit with HI/LO registers.
// Serves MULT, MULTU, DIV and DIVU with 32 shift/add or shift/subtract steps,
// plus MTHI/MTLO moves while idle. Each operation takes 34 cycles: the start edge,
// 32 iteration edges and one sign-fixup edge.
// Optional feature: define MIPS_MULT_DIV_FAST_MULT_EN to finish MULT/MULTU in a
// single cycle using a combinational multiplier. DIV/DIVU are unchanged.
module mips_mult_div #(
    parameter int ITERATIONS = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] OperandA,
    input  logic [31:0] OperandB,
    input  logic        HiWrite,
    input  logic        LoWrite,
    input  logic [31:0] DataIn,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FIXUP = 2'd2
    } state_t;

    localparam logic [4:0] LAST_STEP = 5'(ITERATIONS - 1);

    state_t      state;
    logic [4:0]  counter;
    logic [63:0] prod;        // multiply: accumulator; divide: {remainder, quotient/dividend}
    logic [31:0] b_mag;       // magnitude of the multiplier/divisor
    logic        is_div;
    logic        neg_q;       // product/quotient sign
    logic        neg_r;       // remainder sign (dividend's sign)
    logic        div_zero;

    logic        sign_a;
    logic        sign_b;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [32:0] mul_sum;
    logic [33:0] div_diff;
    logic [63:0] prod_step;
    logic [63:0] prod_neg;
    logic [31:0] quo_fix;
    logic [31:0] rem_fix;

`ifdef MIPS_MULT_DIV_FAST_MULT_EN
    logic [63:0] ext_a;
    logic [63:0] ext_b;
    logic [63:0] fast_prod;

    // Single-cycle product: the low 64 bits of the product of the sign- or
    // zero-extended operands is the correct result for both MULT and MULTU.
    always_comb begin
        ext_a     = op[0] ? {32'd0, OperandA} : {{32{OperandA[31]}}, OperandA};
        ext_b     = op[0] ? {32'd0, OperandB} : {{32{OperandB[31]}}, OperandB};
        fast_prod = ext_a * ext_b;
    end
`endif

    assign busy = (state != IDLE);

    // Operand magnitudes, one iteration step and the final sign fixup.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves one unassigned (no latch).
        sign_a    = ~op[0] & OperandA[31];
        sign_b    = ~op[0] & OperandB[31];
        mag_a     = sign_a ? (32'd0 - OperandA) : OperandA;
        mag_b     = sign_b ? (32'd0 - OperandB) : OperandB;

        // Multiply step: conditionally add the multiplicand into the upper half, then shift right.
        mul_sum   = {1'b0, prod[63:32]} + {1'b0, (prod[0] ? b_mag : 32'd0)};
        // Divide step: shift {rem, dividend} left one bit and try to subtract the divisor.
        div_diff  = {1'b0, prod[63:32], prod[31]} - {2'b00, b_mag};
        prod_step = {mul_sum, prod[31:1]};
        if (is_div) begin
            if (div_diff[33]) begin
                prod_step = {prod[62:0], 1'b0};
            end else begin
                prod_step = {div_diff[31:0], prod[30:0], 1'b1};
            end
        end

        prod_neg  = 64'd0 - prod;
        quo_fix   = neg_q ? (32'd0 - prod[31:0]) : prod[31:0];
        rem_fix   = neg_r ? (32'd0 - prod[63:32]) : prod[63:32];
    end

    // Control FSM together with the HI/LO registers and the done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            counter  <= 5'd0;
            prod     <= 64'd0;
            b_mag    <= 32'd0;
            is_div   <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            div_zero <= 1'b0;
            hi       <= 32'd0;
            lo       <= 32'd0;
            done     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (HiWrite) hi <= DataIn;
                    if (LoWrite) lo <= DataIn;
`ifdef MIPS_MULT_DIV_FAST_MULT_EN
                    if (start && !op[1]) begin
                        hi   <= fast_prod[63:32];
                        lo   <= fast_prod[31:0];
                        done <= 1'b1;
                    end else
`endif
                    if (start) begin
                        prod     <= {32'd0, mag_a};
                        b_mag    <= mag_b;
                        is_div   <= op[1];
                        neg_q    <= sign_a ^ sign_b;
                        neg_r    <= sign_a;
                        div_zero <= op[1] && (OperandB == 32'd0);
                        counter  <= 5'd0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    prod    <= prod_step;
                    counter <= counter + 5'd1;
                    if (counter == LAST_STEP) begin
                        state <= FIXUP;
                    end
                end
                FIXUP: begin
                    if (is_div) begin
                        hi <= rem_fix;
                        lo <= div_zero ? 32'hFFFF_FFFF : quo_fix;
                    end else begin
                        hi <= neg_q ? prod_neg[63:32] : prod[63:32];
                        lo <= neg_q ? prod_neg[31:0]  : prod[31:0];
                    end
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_mult_div.sv
// Directed testbench for mips_mult_div: reset state, signed/unsigned multiply and
// divide, divide by zero, ignored start while busy, MTHI/MTLO moves, mid-operation
// reset and the multiply path selected by MIPS_MULT_DIV_FAST_MULT_EN.
module tb_mips_mult_div;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] OperandA = 32'd0;
    logic [31:0] OperandB = 32'd0;
    logic        HiWrite = 1'b0;
    logic        LoWrite = 1'b0;
    logic [31:0] DataIn = 32'd0;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks = 0;
    int errors = 0;

    mips_mult_div dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .op       (op),
        .OperandA (OperandA),
        .OperandB (OperandB),
        .HiWrite  (HiWrite),
        .LoWrite  (LoWrite),
        .DataIn   (DataIn),
        .busy     (busy),
        .done     (done),
        .hi       (hi),
        .lo       (lo)
    );

    always #5 clk = ~clk;

    // Pulse start for one edge and wait (bounded) until done; cyc counts edges
    // from the start edge (=1) to the edge after which done is seen high.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          output int cyc);
        op = o; OperandA = a; OperandB = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 1;
        while (done !== 1'b1 && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL op_timeout: op=%0b done never seen after %0d cycles", o, cyc);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        checks++; if (hi !== 32'd0)  begin errors++; $display("FAIL reset_hi: got %h want 0", hi); end
        checks++; if (lo !== 32'd0)  begin errors++; $display("FAIL reset_lo: got %h want 0", lo); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    endtask

    task automatic test_multu();
        int cyc;
        run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, cyc);
        checks++; if (cyc !== 34) begin errors++; $display("FAIL multu_latency: got %0d want 34", cyc); end
        checks++; if (hi !== 32'hFFFF_FFFE) begin errors++; $display("FAIL multu_hi: got %h want fffffffe", hi); end
        checks++; if (lo !== 32'h0000_0001) begin errors++; $display("FAIL multu_lo: got %h want 00000001", lo); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL multu_busy_with_done: got %b want 0", busy); end
        @(posedge clk); #1;
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL multu_done_pulse: got %b want 0", done); end
    endtask

    task automatic test_mult();
        int cyc;
        run_op(OP_MULT, 32'hFFFF_FFFD, 32'd7, cyc);
        checks++; if (hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mult_neg_hi: got %h want ffffffff", hi); end
        checks++; if (lo !== 32'hFFFF_FFEB) begin errors++; $display("FAIL mult_neg_lo: got %h want ffffffeb", lo); end
        run_op(OP_MULT, 32'h8000_0000, 32'h8000_0000, cyc);
        checks++; if (hi !== 32'h4000_0000) begin errors++; $display("FAIL mult_min_hi: got %h want 40000000", hi); end
        checks++; if (lo !== 32'h0000_0000) begin errors++; $display("FAIL mult_min_lo: got %h want 00000000", lo); end
    endtask

    task automatic test_div();
        int cyc;
        run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, cyc);
        checks++; if (cyc !== 34) begin errors++; $display("FAIL div_latency: got %0d want 34", cyc); end
        checks++; if (lo !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_neg_lo: got %h want fffffffd", lo); end
        checks++; if (hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div_neg_hi: got %h want ffffffff", hi); end
        run_op(OP_DIVU, 32'd100, 32'd7, cyc);
        checks++; if (lo !== 32'd14) begin errors++; $display("FAIL divu_lo: got %h want 0000000e", lo); end
        checks++; if (hi !== 32'd2)  begin errors++; $display("FAIL divu_hi: got %h want 00000002", hi); end
        run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, cyc);
        checks++; if (lo !== 32'h8000_0000) begin errors++; $display("FAIL div_ovf_lo: got %h want 80000000", lo); end
        checks++; if (hi !== 32'h0000_0000) begin errors++; $display("FAIL div_ovf_hi: got %h want 00000000", hi); end
        run_op(OP_DIV, 32'd7, 32'hFFFF_FFFE, cyc);
        checks++; if (lo !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_negb_lo: got %h want fffffffd", lo); end
        checks++; if (hi !== 32'd1) begin errors++; $display("FAIL div_negb_hi: got %h want 00000001", hi); end
    endtask

    // DIVU 5/0 with a second start pulsed at cycle 10 that must be ignored.
    task automatic test_div_zero_ignored_start();
        int cyc;
        int pulses;
        int first_done;
        pulses = 0;
        first_done = 0;
        op = OP_DIVU; OperandA = 32'd5; OperandB = 32'd0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (cyc = 2; cyc <= 60; cyc++) begin
            if (cyc == 10) begin
                op = OP_MULTU; OperandA = 32'd3; OperandB = 32'd3; start = 1'b1;
            end
            @(posedge clk); #1;
            start = 1'b0;
            if (done === 1'b1) begin
                pulses++;
                if (first_done == 0) first_done = cyc;
            end
        end
        checks++; if (pulses !== 1) begin errors++; $display("FAIL dz_done_pulses: got %0d want 1", pulses); end
        checks++; if (first_done !== 34) begin errors++; $display("FAIL dz_latency: got %0d want 34", first_done); end
        checks++; if (hi !== 32'd5) begin errors++; $display("FAIL dz_hi: got %h want 00000005", hi); end
        checks++; if (lo !== 32'hFFFF_FFFF) begin errors++; $display("FAIL dz_lo: got %h want ffffffff", lo); end
    endtask

    task automatic test_moves();
        int cyc;
        // Move while busy is dropped.
        op = OP_DIVU; OperandA = 32'd100; OperandB = 32'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        HiWrite = 1'b1; DataIn = 32'h0000_1234;
        @(posedge clk); #1;
        HiWrite = 1'b0;
        checks++; if (hi !== 32'd5) begin errors++; $display("FAIL move_busy_dropped: got %h want 00000005", hi); end
        cyc = 0;
        while (done !== 1'b1 && cyc < 100) begin @(posedge clk); #1; cyc++; end
        checks++; if (hi !== 32'd2) begin errors++; $display("FAIL move_busy_result_hi: got %h want 00000002", hi); end
        // Move in IDLE is applied.
        HiWrite = 1'b1; DataIn = 32'h0000_1234;
        @(posedge clk); #1;
        HiWrite = 1'b0;
        checks++; if (hi !== 32'h0000_1234) begin errors++; $display("FAIL mthi_idle: got %h want 00001234", hi); end
        checks++; if (lo !== 32'd14) begin errors++; $display("FAIL mthi_lo_kept: got %h want 0000000e", lo); end
        // Both moves together.
        HiWrite = 1'b1; LoWrite = 1'b1; DataIn = 32'h0000_CAFE;
        @(posedge clk); #1;
        HiWrite = 1'b0; LoWrite = 1'b0;
        checks++; if (hi !== 32'h0000_CAFE) begin errors++; $display("FAIL both_hi: got %h want 0000cafe", hi); end
        checks++; if (lo !== 32'h0000_CAFE) begin errors++; $display("FAIL both_lo: got %h want 0000cafe", lo); end
        // Hold: no writes in idle, registers keep their values.
        repeat (3) @(posedge clk);
        #1;
        checks++; if (hi !== 32'h0000_CAFE) begin errors++; $display("FAIL hold_hi: got %h want 0000cafe", hi); end
        // Start and a move on the same edge: move lands, result overwrites later.
        op = OP_DIVU; OperandA = 32'd100; OperandB = 32'd7; start = 1'b1;
        LoWrite = 1'b1; DataIn = 32'h0000_AAAA;
        @(posedge clk); #1;
        start = 1'b0; LoWrite = 1'b0;
        checks++; if (lo !== 32'h0000_AAAA) begin errors++; $display("FAIL start_move_lo: got %h want 0000aaaa", lo); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL start_move_busy: got %b want 1", busy); end
        cyc = 0;
        while (done !== 1'b1 && cyc < 100) begin @(posedge clk); #1; cyc++; end
        checks++; if (lo !== 32'd14) begin errors++; $display("FAIL start_move_result_lo: got %h want 0000000e", lo); end
    endtask

    task automatic test_reset_mid_op();
        int pulses;
        pulses = 0;
        op = OP_DIV; OperandA = 32'hFFFF_FFF9; OperandB = 32'd2; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (13) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++; if (hi !== 32'd0)  begin errors++; $display("FAIL midrst_hi: got %h want 0", hi); end
        checks++; if (lo !== 32'd0)  begin errors++; $display("FAIL midrst_lo: got %h want 0", lo); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b want 0", busy); end
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (done === 1'b1) pulses++;
        end
        checks++; if (pulses !== 0) begin errors++; $display("FAIL midrst_no_done: got %0d pulses want 0", pulses); end
    endtask

    task automatic test_small_mult();
        int cyc;
        int busy_seen;
        busy_seen = 0;
        op = OP_MULT; OperandA = 32'd6; OperandB = 32'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 1;
        if (busy === 1'b1) busy_seen = 1;
        while (done !== 1'b1 && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
            if (busy === 1'b1) busy_seen = 1;
        end
`ifdef MIPS_MULT_DIV_FAST_MULT_EN
        checks++; if (cyc !== 1) begin errors++; $display("FAIL fast_mult_latency: got %0d want 1", cyc); end
        checks++; if (busy_seen !== 0) begin errors++; $display("FAIL fast_mult_busy: got %0d want 0", busy_seen); end
`else
        checks++; if (cyc !== 34) begin errors++; $display("FAIL mult_small_latency: got %0d want 34", cyc); end
        checks++; if (busy_seen !== 1) begin errors++; $display("FAIL mult_small_busy: got %0d want 1", busy_seen); end
`endif
        checks++; if (lo !== 32'd42) begin errors++; $display("FAIL mult_small_lo: got %h want 0000002a", lo); end
        checks++; if (hi !== 32'd0)  begin errors++; $display("FAIL mult_small_hi: got %h want 00000000", hi); end
    endtask

    initial begin
        @(posedge clk); #1;
        test_reset();
        test_multu();
        test_mult();
        test_div();
        test_div_zero_ignored_start();
        test_moves();
        test_reset_mid_op();
        test_small_mult();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
